// File: rtl/alu_flag_unit.sv
// Status-flag generator for branch decisions: registers ALU result bundles through a
// two-stage valid/ready pipeline and produces zero/negative/carry/overflow plus a sticky overflow.
`timescale 1ns/1ps
module alu_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] op_a,
  input  logic signed [WIDTH-1:0] op_b,
  input  logic signed [WIDTH-1:0] alu_result,
  input  logic                    alu_carry,
  input  logic                    alu_sub,
  input  logic                    flags_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    zero,
  output logic                    negative,
  output logic                    carry,
  output logic                    overflow,
  output logic                    sticky_ovf
);

  logic                    vld_p1, vld_p2;
  logic                    adv_p1, adv_p2;
  logic                    a_neg_p1, b_neg_p1, carry_p1, sub_p1;
  logic signed [WIDTH-1:0] result_p1;

  // Subtraction flips the operand-sign relationship that can produce a signed overflow.
  function automatic logic ovf_flag(input logic a_neg, input logic b_neg,
                                    input logic r_neg, input logic sub);
    return (sub ? (a_neg != b_neg) : (a_neg == b_neg)) & (r_neg != a_neg);
  endfunction

  assign adv_p2    = !vld_p2 || out_ready;
  assign adv_p1    = !vld_p1 || adv_p2;
  assign in_ready  = adv_p1;
  assign out_valid = vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1: capture operand signs and the ALU result on an input handshake
  always_ff @(posedge clk) begin
    if (in_valid && adv_p1) begin
      a_neg_p1  <= (op_a < 0);
      b_neg_p1  <= (op_b < 0);
      result_p1 <= alu_result;
      carry_p1  <= alu_carry;
      sub_p1    <= alu_sub;
    end
  end

  // Stage 2: derive and register the flags seen by the branch logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (vld_p1 && adv_p2) begin
      zero     <= (result_p1 == '0);
      negative <= result_p1[WIDTH-1];
      carry    <= carry_p1;
      overflow <= ovf_flag(a_neg_p1, b_neg_p1, result_p1[WIDTH-1], sub_p1);
    end
  end

  // A transfer carrying overflow takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (vld_p2 && out_ready && overflow) begin
      sticky_ovf <= 1'b1;
    end else if (flags_clear) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: directed vector table, reset/sticky sequences, and a
// scoreboard fed by an arithmetic reference model for streaming traffic.
`timescale 1ns/1ps
module tb_alu_flag_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0, op_b = '0, alu_result = '0;
  logic         alu_carry = 1'b0, alu_sub = 1'b0, flags_clear = 1'b0;
  logic         out_valid, out_ready = 1'b0;
  logic         zero, negative, carry, overflow, sticky_ovf;

  alu_flag_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_sub(alu_sub), .flags_clear(flags_clear), .out_valid(out_valid),
    .out_ready(out_ready), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .sticky_ovf(sticky_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic z, n, c, o; } flags_t;
  typedef struct packed {
    logic [W-1:0] a, b, r;
    logic c, sub, ez, en, ec, eo;
  } vec_t;

  int     total = 0, bad = 0, nxfer = 0;
  flags_t q[$];
  flags_t ef;
  logic   ovx;
  logic   sticky_m = 1'b0;
  logic   mon_en = 1'b0;
  vec_t   tbl[9];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: flags from plain signed/unsigned arithmetic on the full operands.
  function automatic flags_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] r, input logic c, input logic sub);
    flags_t f;
    longint sa, sb, s, maxv, minv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = sub ? sa - sb : sa + sb;
    maxv = (64'sd1 <<< (W-1)) - 1;
    minv = -(64'sd1 <<< (W-1));
    f.z = (r == 0);
    f.n = ($signed(r) < 0);
    f.c = c;
    f.o = (s > maxv) || (s < minv);
    return f;
  endfunction

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] t;
    t = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    op_a = a; op_b = b; alu_sub = sub;
    alu_result = t[W-1:0];
    alu_carry = sub ? ~t[W] : t[W];
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic acc;
    int   n;
    apply(a, b, sub);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    in_valid = 1'b0;
    flags_clear = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    q.delete();
    sticky_m = 1'b0;
    nxfer = 0;
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor, sampled at the falling edge while inputs and outputs are stable.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("mon_sticky", sticky_ovf, sticky_m);
      ovx = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("mon_unexpected_out_valid", 1, 0);
        end else begin
          ef = q[0];
          check("mon_zero", zero, ef.z);
          check("mon_negative", negative, ef.n);
          check("mon_carry", carry, ef.c);
          check("mon_overflow", overflow, ef.o);
          ovx = ef.o;
          if (out_ready) begin
            void'(q.pop_front());
            nxfer++;
          end
        end
      end
      if (out_valid && out_ready && ovx) sticky_m = 1'b1;
      else if (flags_clear) sticky_m = 1'b0;
      if (in_valid && in_ready) q.push_back(model(op_a, op_b, alu_result, alu_carry, alu_sub));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ba[6], bb[6];
    logic         bs[6];
    int           idx, stalls, n;
    logic [W-1:0] ra, rb;
    logic         rs;

    //              a             b             r             c     sub   z     n     c     o
    tbl[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{32'h0000_0003, 32'h0000_0007, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_zero", zero, 0);
    check("rst_negative", negative, 0);
    check("rst_carry", carry, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sticky", sticky_ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Directed table, back to back at two-edge latency
    out_ready = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin
        op_a = tbl[i].a; op_b = tbl[i].b; alu_result = tbl[i].r;
        alu_carry = tbl[i].c; alu_sub = tbl[i].sub; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        check($sformatf("tbl%0d_valid", i-1), out_valid, 1);
        check($sformatf("tbl%0d_zero", i-1), zero, tbl[i-1].ez);
        check($sformatf("tbl%0d_negative", i-1), negative, tbl[i-1].en);
        check($sformatf("tbl%0d_carry", i-1), carry, tbl[i-1].ec);
        check($sformatf("tbl%0d_overflow", i-1), overflow, tbl[i-1].eo);
      end
    end

    // Reset in the middle of a transfer
    do_reset();
    out_ready = 1'b1;
    op_a = tbl[2].a; op_b = tbl[2].b; alu_result = tbl[2].r;
    alu_carry = tbl[2].c; alu_sub = tbl[2].sub; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_overflow", overflow, 1);
    check("mid_pre_sticky", sticky_ovf, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_negative", negative, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_sticky", sticky_ovf, 0);
    rst_n = 1'b1;
    op_a = tbl[1].a; op_b = tbl[1].b; alu_result = tbl[1].r;
    alu_carry = tbl[1].c; alu_sub = tbl[1].sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_lat1_valid", out_valid, 0);
    @(posedge clk); #1;
    check("mid_lat2_valid", out_valid, 1);
    check("mid_lat2_negative", negative, 1);
    check("mid_lat2_zero", zero, 0);
    @(posedge clk); #1;
    check("mid_no_stale", out_valid, 0);

    // Backpressure with out_ready pattern 1,0,0
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ba[i] = $urandom; bb[i] = $urandom; bs[i] = $urandom_range(0, 1);
    end
    ba[2] = 32'h7FFF_FFF0; bb[2] = 32'h0000_0100; bs[2] = 1'b0;
    idx = 0; stalls = 0;
    for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
      out_ready = (cyc % 3 == 0);
      apply(ba[idx], bb[idx], bs[idx]);
      @(negedge clk);
      if (in_ready) idx++; else stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_all_sent", idx, 6);
    check("bp_in_ready_dropped", (stalls > 0), 1);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("bp_drained", q.size(), 0);
    check("bp_transfers", nxfer, 6);

    // Sticky overflow set, hold, clear, and set-wins-over-clear
    do_reset();
    mon_en = 1'b1;
    out_ready = 1'b1;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    for (int i = 0; i < 5; i++) send(i, 32'h1, 1'b0);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("sticky_held", sticky_ovf, 1);
    flags_clear = 1'b1;
    @(posedge clk); #1;
    flags_clear = 1'b0;
    check("sticky_cleared", sticky_ovf, 0);
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    flags_clear = 1'b1;
    @(posedge clk); #1;
    flags_clear = 1'b0;
    check("sticky_set_wins", sticky_ovf, 1);
    flags_clear = 1'b1;
    @(posedge clk); #1;
    flags_clear = 1'b0;
    check("sticky_cleared2", sticky_ovf, 0);

    // Full-throughput random stream
    do_reset();
    mon_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rs = $urandom_range(0, 1);
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      apply(ra, rb, rs);
      @(negedge clk);
      check("tp_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("tp_transfers", nxfer, 100);
    check("tp_idle_after", out_valid, 0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
Producer side of the branch-decision path: this block generates the status flags (zero, negative, carry, overflow) that the branch logic ANDs with its control signals. It takes ALU results with their operands and produces registered flags through a two-stage valid/ready pipeline. It also keeps a sticky overflow bit for exception reporting. It sits between the ALU output and the branch/PC-select logic.

Parameters:
WIDTH, 32, datapath width of operands and ALU result (minimum 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/result bundle is valid this cycle
in_ready  output  1  block accepts the bundle this cycle
op_a  input  WIDTH  ALU operand A
op_b  input  WIDTH  ALU operand B
alu_result  input  WIDTH  ALU result for op_a/op_b
alu_carry  input  1  ALU carry-out (for subtraction, 1 = no borrow)
alu_sub  input  1  1 = operation was subtraction, 0 = addition or logical
flags_clear  input  1  synchronous clear of sticky_ovf
out_valid  output  1  flags below are valid
out_ready  input  1  consumer accepts the flags
zero  output  1  alu_result == 0
negative  output  1  alu_result[WIDTH-1]
carry  output  1  registered alu_carry
overflow  output  1  signed overflow of the add/sub
sticky_ovf  output  1  set by any transferred overflow, held until flags_clear

Behaviour:
- Reset (rst_n low, asynchronous): all stage-valid bits 0. out_valid=0, zero=0, negative=0, carry=0, overflow=0, sticky_ovf=0. The pipeline contents are discarded even if a reset arrives mid-transfer.
- Stage 1 (S1) registers op_a MSB, op_b MSB, alu_result, alu_carry and alu_sub on an input handshake (in_valid & in_ready).
- Stage 2 (S2) computes the flags from S1 and registers them. Flag outputs come from S2 registers only; there is no combinational path from the inputs to the outputs.
- Latency: an input accepted at edge N produces out_valid=1 after edge N+2 when no backpressure is applied.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
  - An S1 entry moves to S2 when s1_valid & s2_adv.
- Full throughput: one bundle per cycle while out_ready=1. When out_ready=0 with both stages full, in_ready=0 and all registers hold. No bundle is dropped or duplicated.
- Output stability: while out_valid & !out_ready, all flag outputs are held constant.
- Flag arithmetic (a=op_a MSB, b=op_b MSB, r=alu_result MSB):
  - zero = ~|alu_result; negative = r; carry = alu_carry.
  - Add (alu_sub=0): overflow = (a==b) & (r!=a).
  - Sub (alu_sub=1): overflow = (a!=b) & (r!=a).
  - Logical ops use alu_sub=0. Their overflow result is meaningless; the consumer ignores it.
- sticky_ovf:
  - Set on the cycle an S2 entry with overflow=1 is transferred (out_valid & out_ready & overflow).
  - Cleared by flags_clear.
  - If set and clear happen in the same cycle, set wins and sticky_ovf=1.
- flags_clear does not affect the pipeline or handshakes.
- in_valid is ignored while in_ready=0. The upstream holds its bundle until the handshake completes.

Test Plan:
- Reset mid-flow: load 2 bundles, assert rst_n=0 for 1 ns between edges -> out_valid, all flags and sticky_ovf go 0 immediately; the next accepted bundle appears after exactly 2 edges.
- Zero/negative: alu_result=0x00000000 -> zero=1, negative=0; then 0x80000000 -> zero=0, negative=1, both at 2-cycle latency back to back.
- Overflow add/sub:
  - add 0x7FFFFFFF+0x00000001, result 0x80000000, carry=0 -> overflow=1.
  - sub 0x80000000-0x00000001, result 0x7FFFFFFF, carry=1 -> overflow=1, carry=1.
  - sub 5-5, result 0 -> overflow=0, zero=1.
- Backpressure: stream 6 bundles with out_ready toggling 1,0,0,1,... -> in_ready drops when both stages are full; output order and values match the input order exactly; flags stay stable while stalled.
- Sticky: transfer one overflow bundle -> sticky_ovf=1 and stays 1 over 5 non-overflow transfers; pulse flags_clear -> 0; pulse flags_clear on the same cycle as an overflow transfer -> stays 1.
- Throughput: 100 random bundles with out_ready=1 and in_valid=1 -> in_ready constantly 1, 100 outputs in 101 cycles after the first acceptance, all flags match a reference model.
